// File: rtl/vtree_way_fetcher.sv
// Request scheduler for the virtual merge sorter tree: walks a merge pass in groups
// of WAYS runs and issues credit-gated, round-robin block fetches per input way.
module vtree_way_fetcher #(
    parameter int W_LOG    = 3,
    parameter int ADDRW    = 32,
    parameter int CRED_LOG = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  BYPASS,
    input  logic [ADDRW-1:0]      RUNLEN_BLK,
    input  logic [ADDRW-1:0]      TOTAL_BLK,
    input  logic                  REQ_READY,
    input  logic [(1<<W_LOG)-1:0] DEQ,
    output logic                  REQ_VALID,
    output logic [W_LOG-1:0]      REQ_WAY,
    output logic [ADDRW-1:0]      REQ_ADDR,
    output logic [(1<<W_LOG)-1:0] WAY_END,
    output logic                  BUSY,
    output logic                  DONE
);
    localparam int WAYS = 1 << W_LOG;
    localparam int CW   = ADDRW + W_LOG + 1;
    localparam logic [CRED_LOG:0] CRED     = {1'b1, {CRED_LOG{1'b0}}};
    localparam logic [CRED_LOG:0] CRED_ONE = {{CRED_LOG{1'b0}}, 1'b1};
    localparam logic [ADDRW-1:0]  ONE_A    = {{(ADDRW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_t;

    state_t               state_q, state_d;
    logic                 bypass_q, bypass_d;
    logic [ADDRW-1:0]     runlen_q, runlen_d;
    logic [ADDRW-1:0]     total_q, total_d;
    logic [CW-1:0]        base_q, base_d;
    logic [ADDRW-1:0]     remain_q [WAYS];
    logic [ADDRW-1:0]     remain_d [WAYS];
    logic [ADDRW-1:0]     addr_q [WAYS];
    logic [ADDRW-1:0]     addr_d [WAYS];
    logic [CRED_LOG:0]    credit_q [WAYS];
    logic [CRED_LOG:0]    credit_d [WAYS];
    logic [W_LOG-1:0]     ptr_q, ptr_d;
    logic                 req_valid_q, req_valid_d;
    logic [W_LOG-1:0]     req_way_q, req_way_d;
    logic [ADDRW-1:0]     req_addr_q, req_addr_d;
    logic [WAYS-1:0]      way_end_q, way_end_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 hs;
    logic [ADDRW-1:0]     rem_post [WAYS];
    logic [ADDRW-1:0]     addr_post [WAYS];
    logic [CRED_LOG:0]    cred_post [WAYS];
    logic                 pick_ok;
    logic [W_LOG-1:0]     pick_way;
    logic [W_LOG-1:0]     idx;
    logic                 all_empty;
    logic [CW-1:0]        start_c;
    logic [CW-1:0]        diff_c;
    logic [CW-1:0]        grp_next;

    assign hs = req_valid_q && REQ_READY;

    // Counts as they will be after this cycle's handshake and DEQ pulses, so the
    // next request can be chosen on the same edge that retires the current one.
    always_comb begin
        pick_ok   = 1'b0;
        pick_way  = '0;
        idx       = '0;
        all_empty = 1'b1;
        for (int w = 0; w < WAYS; w++) begin
            rem_post[w]  = remain_q[w];
            addr_post[w] = addr_q[w];
            cred_post[w] = credit_q[w];
            if (remain_q[w] != '0) all_empty = 1'b0;
            if (hs && req_way_q == W_LOG'(w)) begin
                rem_post[w]  = remain_q[w] - ONE_A;
                addr_post[w] = addr_q[w] + ONE_A;
                if (!DEQ[w]) cred_post[w] = credit_q[w] - CRED_ONE;
            end else if (DEQ[w] && credit_q[w] != CRED) begin
                cred_post[w] = credit_q[w] + CRED_ONE;
            end
        end
        for (int k = 0; k < WAYS; k++) begin
            idx = ptr_q + W_LOG'(k);
            if (!pick_ok && rem_post[idx] != '0 && cred_post[idx] != '0) begin
                pick_ok  = 1'b1;
                pick_way = idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        bypass_d    = bypass_q;
        runlen_d    = runlen_q;
        total_d     = total_q;
        base_d      = base_q;
        ptr_d       = ptr_q;
        req_valid_d = req_valid_q;
        req_way_d   = req_way_q;
        req_addr_d  = req_addr_q;
        way_end_d   = way_end_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        start_c     = '0;
        diff_c      = '0;
        grp_next    = base_q + (CW'(runlen_q) << W_LOG);
        for (int w = 0; w < WAYS; w++) begin
            remain_d[w] = remain_q[w];
            addr_d[w]   = addr_q[w];
            credit_d[w] = cred_post[w];
        end
        case (state_q)
            IDLE: begin
                if (START) begin
                    bypass_d = BYPASS;
                    runlen_d = RUNLEN_BLK;
                    total_d  = TOTAL_BLK;
                    base_d   = '0;
                    ptr_d    = '0;
                    busy_d   = 1'b1;
                    state_d  = (RUNLEN_BLK == '0 || TOTAL_BLK == '0) ? FIN : LOAD;
                end
            end
            LOAD: begin
                // Wide arithmetic keeps start/remaining exact even for the last ways.
                for (int w = 0; w < WAYS; w++) begin
                    start_c   = base_q + CW'(w) * CW'(runlen_q);
                    diff_c    = CW'(total_q) - start_c;
                    addr_d[w] = start_c[ADDRW-1:0];
                    if (bypass_q)                      remain_d[w] = (w == 0) ? total_q : '0;
                    else if (start_c >= CW'(total_q))  remain_d[w] = '0;
                    else if (diff_c < CW'(runlen_q))   remain_d[w] = diff_c[ADDRW-1:0];
                    else                               remain_d[w] = runlen_q;
                    way_end_d[w] = (remain_d[w] == '0);
                end
                state_d = RUN;
            end
            RUN: begin
                for (int w = 0; w < WAYS; w++) begin
                    remain_d[w] = rem_post[w];
                    addr_d[w]   = addr_post[w];
                    if (hs && req_way_q == W_LOG'(w) && rem_post[w] == '0) way_end_d[w] = 1'b1;
                end
                if (!req_valid_q || hs) begin
                    req_valid_d = pick_ok;
                    if (pick_ok) begin
                        req_way_d  = pick_way;
                        req_addr_d = addr_post[pick_way];
                        ptr_d      = pick_way + W_LOG'(1);
                    end
                end
                if (!req_valid_q && all_empty) begin
                    if (bypass_q || grp_next >= CW'(total_q)) begin
                        state_d = FIN;
                    end else begin
                        base_d  = grp_next;
                        state_d = LOAD;
                    end
                end
            end
            FIN: begin
                req_valid_d = 1'b0;
                way_end_d   = '1;
                busy_d      = 1'b0;
                done_d      = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Credits survive across passes; only reset refills them.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            bypass_q    <= 1'b0;
            runlen_q    <= '0;
            total_q     <= '0;
            base_q      <= '0;
            ptr_q       <= '0;
            req_valid_q <= 1'b0;
            req_way_q   <= '0;
            req_addr_q  <= '0;
            way_end_q   <= '1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            for (int w = 0; w < WAYS; w++) begin
                remain_q[w] <= '0;
                addr_q[w]   <= '0;
                credit_q[w] <= CRED;
            end
        end else begin
            state_q     <= state_d;
            bypass_q    <= bypass_d;
            runlen_q    <= runlen_d;
            total_q     <= total_d;
            base_q      <= base_d;
            ptr_q       <= ptr_d;
            req_valid_q <= req_valid_d;
            req_way_q   <= req_way_d;
            req_addr_q  <= req_addr_d;
            way_end_q   <= way_end_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            for (int w = 0; w < WAYS; w++) begin
                remain_q[w] <= remain_d[w];
                addr_q[w]   <= addr_d[w];
                credit_q[w] <= credit_d[w];
            end
        end
    end

    assign REQ_VALID = req_valid_q;
    assign REQ_WAY   = req_way_q;
    assign REQ_ADDR  = req_addr_q;
    assign WAY_END   = way_end_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
endmodule
